restoring_div_seq: RTL and testbench

RESTORING_DIV_SEQ -- requirements
Module: restoring_div_seq

---
 rtl/restoring_div_seq.sv | 122 ++++++++++++
 tb/tb_restoring_div_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/restoring_div_seq.sv
// Sequential 8-bit unsigned restoring divider: one quotient bit per cycle.
// It takes 8 iteration cycles between the start edge and the cycle with done high.
// Optional feature: define DIV_ZERO_CHECK_EN to send a zero divisor straight
// to DONE with quotient=8'hFF, remainder=dividend and div_by_zero set.
// Without the macro, a zero divisor runs the normal sequence and div_by_zero
// is tied low.
module restoring_div_seq (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

  state_e     state_q;
  // Bit 8 of A is only needed inside a step; between steps the restored
  // partial remainder is always below M, so 8 stored bits suffice.
  logic [7:0] a_q;
  logic [7:0] q_q;
  logic [7:0] m_q;
  logic [2:0] cnt_q;

  logic [8:0] a_shift;
  logic [8:0] a_diff;
  logic [7:0] a_step;
  logic [7:0] q_step;

  // One restoring step: shift {A,Q} left, trial-subtract M, restore on borrow.
  always_comb begin
    a_shift = {a_q, q_q[7]};
    a_diff  = a_shift - {1'b0, m_q};
    a_step  = a_diff[7:0];
    q_step  = {q_q[6:0], 1'b1};
    if (a_diff[8]) begin
      // Borrow: the shifted value was below M, so it fits in 8 bits.
      a_step = a_shift[7:0];
      q_step = {q_q[6:0], 1'b0};
    end
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      a_q       <= 8'h00;
      q_q       <= 8'h00;
      m_q       <= 8'h00;
      cnt_q     <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= 8'h00;
      remainder <= 8'h00;
`ifdef DIV_ZERO_CHECK_EN
      div_by_zero <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q   <= 8'h00;
            q_q   <= dividend;
            m_q   <= divisor;
            cnt_q <= 3'd0;
`ifdef DIV_ZERO_CHECK_EN
            if (divisor == 8'h00) begin
              state_q     <= StDone;
              done        <= 1'b1;
              quotient    <= 8'hFF;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state_q <= StIter;
              busy    <= 1'b1;
            end
`else
            state_q <= StIter;
            busy    <= 1'b1;
`endif
          end
        end
        StIter: begin
          a_q <= a_step;
          q_q <= q_step;
          if (cnt_q == 3'd7) begin
            // Eighth step: publish the result; the count holds rather than wrap.
            state_q   <= StDone;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_step;
            remainder <= a_step;
`ifdef DIV_ZERO_CHECK_EN
            div_by_zero <= 1'b0;
`endif
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

`ifndef DIV_ZERO_CHECK_EN
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_restoring_div_seq.sv
// Directed self-checking bench for restoring_div_seq.
// "done cycle" n means done was seen in the n-th cycle after the start edge
// (1 = the cycle right after the start edge).
module tb_restoring_div_seq;

  logic       clk;
  logic       rstn;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  restoring_div_seq dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a one-cycle start; returns 1 time unit after the start edge.
  task automatic start_div(input logic [7:0] dd, input logic [7:0] dv);
    @(negedge clk);
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Bounded wait for done; reports done cycle (-1 on timeout), busy cycles
  // seen before it, and whether the result outputs held steady meanwhile.
  task automatic wait_done(output int lat, output int busy_cyc, output bit held);
    logic [7:0] q0;
    logic [7:0] r0;
    q0 = quotient;
    r0 = remainder;
    lat = -1;
    busy_cyc = 0;
    held = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (busy) busy_cyc++;
      if (done) begin
        lat = n;
        break;
      end
      if (quotient !== q0 || remainder !== r0) held = 1'b0;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; start = 1'b0; dividend = 8'h00; divisor = 8'h00;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_basic;
    int lat, bc;
    bit held;
    start_div(8'd100, 8'd7);
    wait_done(lat, bc, held);
    n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want 9", lat); end
    n_checks++; if (bc !== 8) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d want 8", bc); end
    n_checks++; if (!held) begin n_fail++; $display("FAIL basic_hold_during_iter: outputs changed before done"); end
    n_checks++; if (quotient !== 8'd14) begin n_fail++; $display("FAIL basic_quotient: got %0d want 14", quotient); end
    n_checks++; if (remainder !== 8'd2) begin n_fail++; $display("FAIL basic_remainder: got %0d want 2", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL basic_dz: got %b want 0", div_by_zero); end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || quotient !== 8'd14 || remainder !== 8'd2) begin
      n_fail++;
      $display("FAIL basic_after_done: got done=%b q=%0d r=%0d want 0/14/2", done, quotient, remainder);
    end
  endtask

  task automatic test_pairs;
    logic [7:0] dd [3];
    logic [7:0] dv [3];
    logic [7:0] eq [3];
    logic [7:0] er [3];
    int lat, bc;
    bit held;
    dd = '{8'd255, 8'd255, 8'd5};
    dv = '{8'd1,   8'd255, 8'd9};
    eq = '{8'd255, 8'd1,   8'd0};
    er = '{8'd0,   8'd0,   8'd5};
    for (int i = 0; i < 3; i++) begin
      start_div(dd[i], dv[i]);
      wait_done(lat, bc, held);
      n_checks++;
      if (lat !== 9) begin n_fail++; $display("FAIL pair%0d_done_cycle: got %0d want 9", i, lat); end
      n_checks++;
      if (quotient !== eq[i]) begin
        n_fail++; $display("FAIL pair%0d_quotient: got %0d want %0d", i, quotient, eq[i]);
      end
      n_checks++;
      if (remainder !== er[i]) begin
        n_fail++; $display("FAIL pair%0d_remainder: got %0d want %0d", i, remainder, er[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    int lat, bc;
    bit held;
    int exp_lat, exp_bc;
    logic exp_dz;
`ifdef DIV_ZERO_CHECK_EN
    exp_lat = 1; exp_bc = 0; exp_dz = 1'b1;
`else
    exp_lat = 9; exp_bc = 8; exp_dz = 1'b0;
`endif
    start_div(8'd200, 8'd0);
    wait_done(lat, bc, held);
    n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL dz_done_cycle: got %0d want %0d", lat, exp_lat); end
    n_checks++; if (bc !== exp_bc) begin n_fail++; $display("FAIL dz_busy_cycles: got %0d want %0d", bc, exp_bc); end
    n_checks++; if (quotient !== 8'hFF) begin n_fail++; $display("FAIL dz_quotient: got %0h want ff", quotient); end
    n_checks++; if (remainder !== 8'd200) begin n_fail++; $display("FAIL dz_remainder: got %0d want 200", remainder); end
    n_checks++; if (div_by_zero !== exp_dz) begin n_fail++; $display("FAIL dz_flag: got %b want %b", div_by_zero, exp_dz); end
    // A following nonzero division clears the flag at its completion.
    start_div(8'd9, 8'd3);
    n_checks++;
    if (div_by_zero !== exp_dz) begin n_fail++; $display("FAIL dz_hold_during_iter: got %b want %b", div_by_zero, exp_dz); end
    wait_done(lat, bc, held);
    n_checks++;
    if (quotient !== 8'd3 || remainder !== 8'd0 || div_by_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL dz_clear: got q=%0d r=%0d dz=%b want 3/0/0", quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_start_ignored;
    int lat, bc, dones, done_at;
    bit held;
    dones = 0;
    done_at = -1;
    start_div(8'd100, 8'd7);
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (done) begin dones++; done_at = n; end
      if (n == 3) begin start = 1'b1; dividend = 8'd50; divisor = 8'd5; end
      if (n == 4) begin
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL ign_busy_after_pulse: got %b want 1", busy); end
      end
    end
    n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL ign_done_pulses: got %0d want 1", dones); end
    n_checks++; if (done_at !== 9) begin n_fail++; $display("FAIL ign_done_cycle: got %0d want 9", done_at); end
    n_checks++;
    if (quotient !== 8'd14 || remainder !== 8'd2) begin
      n_fail++; $display("FAIL ign_result: got q=%0d r=%0d want 14/2", quotient, remainder);
    end
    // Earliest possible restart: the tenth edge after the first start.
    start_div(8'd50, 8'd5);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL e10_accept: busy got %b want 1", busy); end
    wait_done(lat, bc, held);
    n_checks++;
    if (lat !== 9 || quotient !== 8'd10 || remainder !== 8'd0) begin
      n_fail++; $display("FAIL e10_result: got cyc=%0d q=%0d r=%0d want 9/10/0", lat, quotient, remainder);
    end
  endtask

  task automatic test_reset_abort;
    int lat, bc, dones;
    bit held;
    dones = 0;
    start_div(8'd100, 8'd7);
    repeat (4) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'h0) begin
      n_fail++;
      $display("FAIL abort_async_clear: got busy=%b done=%b q=%0d r=%0d dz=%b want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    n_checks++; if (dones !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d active cycles want 0", dones); end
    // Release reset and request a division for the very first edge.
    @(negedge clk);
    rstn = 1'b1; start = 1'b1; dividend = 8'd9; divisor = 8'd2;
    @(posedge clk);
    #1 start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_first_edge_accept: busy got %b want 1", busy); end
    wait_done(lat, bc, held);
    n_checks++;
    if (lat !== 9 || quotient !== 8'd4 || remainder !== 8'd1) begin
      n_fail++; $display("FAIL abort_restart_result: got cyc=%0d q=%0d r=%0d want 9/4/1", lat, quotient, remainder);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pairs();
    test_div_zero();
    test_start_ignored();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
